// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, constants and byte-merge helper for mem_bank
`timescale 1ns/1ps
package mem_pkg;

    typedef enum logic {ST_IDLE, ST_CLEAR} mem_state_t;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    // Widest word be_merge handles; callers zero-extend and truncate around it.
    localparam int MEM_MAX_W  = 256;
    localparam int MEM_MAX_BE = MEM_MAX_W / 8;

    function automatic logic [MEM_MAX_W-1:0] be_merge(
        input logic [MEM_MAX_W-1:0]  old_word,
        input logic [MEM_MAX_W-1:0]  new_word,
        input logic [MEM_MAX_BE-1:0] be
    );
        logic [MEM_MAX_W-1:0] res;
        for (int i = 0; i < MEM_MAX_BE; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - RD_LAT-deep valid+data shift register for read responses
`timescale 1ns/1ps
module mem_rd_pipe #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  dat_q [RD_LAT];
    logic [WIDTH-1:0]  dat_d [RD_LAT];

    always_comb begin
        vld_d[0] = in_valid;
        dat_d[0] = in_valid ? in_data : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_data  = out_valid ? dat_q[RD_LAT-1] : '0;

endmodule

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - single-port RAM bank with byte enables, read pipeline and clear sweep
`timescale 1ns/1ps
module mem_bank
    import mem_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rw,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    input  logic [WIDTH/8-1:0]   req_be,
    input  logic                 clear,
    output logic                 rsp_valid,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              accept, rd_acc, mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata, rd_word, merged;

    assign rd_word = mem[req_addr];
    assign merged  = WIDTH'(be_merge(MEM_MAX_W'(rd_word), MEM_MAX_W'(req_wdata),
                                     MEM_MAX_BE'(req_be)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        rd_acc    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = merged;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                // Counter holds at the top address on exit; entry to CLEAR reloads it.
                if (&cnt_q) state_d = ST_IDLE;
                else        cnt_d   = cnt_q + ADDR_W'(1);
            end
            default: begin
                req_ready = !clear;
                accept    = req_valid && !clear;
                rd_acc    = accept && (req_rw == MEM_RD);
                mem_we    = accept && (req_rw == MEM_WR) && (|req_be);
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign busy = (state_q == ST_CLEAR);

    mem_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (rsp_valid),
        .out_data  (rsp_data)
    );

endmodule

// File: tb/tb_mem_bank.sv
// tb/tb_mem_bank.sv - directed bench for mem_bank at RD_LAT=1 and RD_LAT=2
`timescale 1ns/1ps
module tb_mem_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_rw, clear;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        ready1, ready2, rv1, rv2, busy1, busy2;
    logic [31:0] rd1, rd2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_bank #(.WIDTH(32), .ADDR_W(4), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .clear(clear), .rsp_valid(rv1), .rsp_data(rd1), .busy(busy1)
    );

    mem_bank #(.WIDTH(32), .ADDR_W(4), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .clear(clear), .rsp_valid(rv2), .rsp_data(rd2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
        req_wdata = '0;   req_be = '0;   clear = 1'b0;
    endtask

    task automatic set_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = a; req_wdata = d; req_be = be;
    endtask

    task automatic set_rd(input logic [3:0] a);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_wdata = '0; req_be = '0;
    endtask

    // Call just after the edge that started the sweep; runs until IDLE.
    task automatic sweep_check(input string tag);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk({tag, "_busy"},  {31'b0, busy1 & busy2}, 32'd1);
            chk({tag, "_ready"}, {31'b0, ready1 | ready2}, 32'd0);
        end
        tick();
        chk({tag, "_busy_end"},  {30'b0, busy2, busy1},  32'd0);
        chk({tag, "_ready_end"}, {30'b0, ready2, ready1}, 32'd3);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #12;
        chk("rst_busy",  {30'b0, busy2, busy1},  32'd3);
        chk("rst_ready", {30'b0, ready2, ready1}, 32'd0);
        chk("rst_rv",    {30'b0, rv2, rv1},      32'd0);
        chk("rst_rd",    rd1 | rd2,              32'd0);
        tick();
        reset = 1'b0;
        sweep_check("init");

        // Every address reads zero after the initial sweep, one response per accept.
        for (int i = 0; i < 16; i++) begin
            set_rd(4'(i));
            tick();
            chk("init_rd_v", {31'b0, rv1}, 32'd1);
            chk("init_rd_d", rd1,          32'd0);
        end
        idle_inputs();
        tick();
        chk("init_rd_tail_v1", {31'b0, rv1}, 32'd0);
        chk("init_rd_tail_v2", {31'b0, rv2}, 32'd1);

        // Byte-enable merge, then a be=0 write that must change nothing.
        set_wr(4'd3, 32'hDEADBEEF, 4'b1111); tick();
        set_wr(4'd3, 32'h000000AA, 4'b0001); tick();
        set_wr(4'd3, 32'h12345678, 4'b0000); tick();
        chk("be0_no_rsp", {30'b0, rv2, rv1}, 32'd0);
        set_rd(4'd3); tick();
        chk("be_rd1", rd1, 32'hDEADBEAA);
        idle_inputs(); tick();
        chk("be_rd2_v", {31'b0, rv2}, 32'd1);
        chk("be_rd2",   rd2, 32'hDEADBEAA);

        // Back-to-back reads; RD_LAT=2 responses trail by one cycle.
        set_wr(4'd1, 32'h11, 4'hF); tick();
        set_wr(4'd2, 32'h22, 4'hF); tick();
        chk("b2b_pre_v2", {31'b0, rv2}, 32'd0);
        chk("b2b_pre_d2", rd2,          32'd0);
        set_rd(4'd1); tick();
        chk("b2b_e0_v2", {31'b0, rv2}, 32'd0);
        chk("b2b_e0_d2", rd2,          32'd0);
        chk("b2b_e0_d1", rd1,          32'h11);
        set_rd(4'd2); tick();
        chk("b2b_e1_v2", {31'b0, rv2}, 32'd1);
        chk("b2b_e1_d2", rd2,          32'h11);
        chk("b2b_e1_d1", rd1,          32'h22);
        idle_inputs(); tick();
        chk("b2b_e2_v2", {31'b0, rv2}, 32'd1);
        chk("b2b_e2_d2", rd2,          32'h22);
        chk("b2b_e2_v1", {31'b0, rv1}, 32'd0);
        tick();
        chk("b2b_e3_v2", {31'b0, rv2}, 32'd0);
        chk("b2b_e3_d2", rd2,          32'd0);

        // Write, read-after-write, then clear while the RD_LAT=2 read is in flight.
        set_wr(4'd5, 32'h5, 4'hF); tick();
        set_rd(4'd5); tick();
        chk("raw_d1", rd1, 32'h5);
        idle_inputs(); clear = 1'b1; #1;
        chk("clr_ready_comb", {30'b0, ready2, ready1}, 32'd0);
        tick();
        clear = 1'b0;
        chk("clr_inflight_v2", {31'b0, rv2}, 32'd1);
        chk("clr_inflight_d2", rd2,          32'h5);
        chk("clr_busy",        {30'b0, busy2, busy1}, 32'd3);
        for (int k = 1; k < 16; k++) begin
            clear = (k == 6);
            tick();
            chk("clr_sweep_busy", {31'b0, busy1 & busy2}, 32'd1);
        end
        clear = 1'b0;
        tick();
        chk("clr_done_ready", {30'b0, ready2, ready1}, 32'd3);
        set_rd(4'd5); tick();
        chk("clr_rd5", rd1, 32'd0);
        idle_inputs(); tick();

        // Clear together with a write: the write is refused and the sweep runs.
        set_wr(4'd7, 32'h77, 4'hF); clear = 1'b1; #1;
        chk("clrw_ready", {30'b0, ready2, ready1}, 32'd0);
        tick();
        idle_inputs();
        sweep_check("clrw");
        set_rd(4'd7); tick();
        chk("clrw_rd7", rd1, 32'd0);
        idle_inputs(); tick();

        // Reset with a read in flight.
        set_wr(4'd9, 32'h99, 4'hF); tick();
        set_rd(4'd9); tick();
        idle_inputs();
        chk("rstf_pre_d1", rd1, 32'h99);
        reset = 1'b1; #1;
        chk("rstf_rv",    {30'b0, rv2, rv1}, 32'd0);
        chk("rstf_rd",    rd1 | rd2,         32'd0);
        chk("rstf_busy",  {30'b0, busy2, busy1}, 32'd3);
        tick();
        chk("rstf_hold_rv", {30'b0, rv2, rv1}, 32'd0);
        reset = 1'b0;
        sweep_check("rstf");
        set_rd(4'd9); tick();
        chk("rstf_rd9", rd1, 32'd0);
        idle_inputs(); tick();

        // Reset at sweep cycle 8.
        clear = 1'b1; tick(); clear = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("rsts_mid_busy", {30'b0, busy2, busy1}, 32'd3);
        reset = 1'b1; #1;
        chk("rsts_busy",  {30'b0, busy2, busy1},  32'd3);
        chk("rsts_ready", {30'b0, ready2, ready1}, 32'd0);
        tick();
        reset = 1'b0;
        sweep_check("rsts");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
